uart_rx: RTL and testbench



---
 rtl/uart_rx_pkg.sv | 17 +
 rtl/rx_sync.sv | 21 ++
 rtl/uart_rx.sv | 124 ++++++++++++
 tb/tb_uart_rx.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Constants shared by the UART transmitter and receiver: default bit timing, frame
// shape and the receive FSM state encoding.
package uart_rx_pkg;

  // 25 MHz / 9600 baud
  localparam int unsigned DefaultBitTime = 2604;
  localparam int unsigned DataBits       = 8;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StStart = 3'd1,
    StData  = 3'd2,
    StStop  = 3'd3,
    StBreak = 3'd4
  } state_e;

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchronizer for an asynchronous input; both flops reset to 1 (idle level).
module rx_sync (
  input  logic clk,
  input  logic clr,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (clr) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling from a synchronised RxD, byte register with
// rdrf / framing-error / overrun flags.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned BIT_TIME = DefaultBitTime,
  parameter int unsigned HALF_BIT = BIT_TIME / 2
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       RxD,
  input  logic       rdrf_clr,
  output logic [7:0] rx_data,
  output logic       rdrf,
  output logic       fe,
  output logic       oe
);

  localparam int unsigned CntW = $clog2(BIT_TIME);
  localparam logic [CntW-1:0] CntBitEnd  = CntW'(BIT_TIME - 1);
  localparam logic [CntW-1:0] CntHalfEnd = CntW'(HALF_BIT - 1);
  localparam logic [2:0]      BitLast    = 3'(DataBits - 1);

  logic rxs;

  rx_sync u_sync (
    .clk(clk),
    .clr(clr),
    .d  (RxD),
    .q  (rxs)
  );

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [2:0]            bitn_q, bitn_d;
  logic [DataBits-1:0]   shreg_q, shreg_d;
  logic [DataBits-1:0]   data_q, data_d;
  logic                  rdrf_q, rdrf_d;
  logic                  fe_q, fe_d;
  logic                  oe_q, oe_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bitn_d  = bitn_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    rdrf_d  = rdrf_q & ~rdrf_clr;
    fe_d    = fe_q;
    oe_d    = oe_q;

    unique case (state_q)
      StIdle: begin
        cnt_d  = '0;
        bitn_d = '0;
        if (!rxs) state_d = StStart;
      end
      StStart: begin
        if (cnt_q == CntHalfEnd) begin
          cnt_d   = '0;
          // Line back high at the start-bit centre: treat as a glitch.
          state_d = rxs ? StIdle : StData;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StData: begin
        if (cnt_q == CntBitEnd) begin
          shreg_d = {rxs, shreg_q[DataBits-1:1]};
          cnt_d   = '0;
          bitn_d  = bitn_q + 3'd1;
          if (bitn_q == BitLast) state_d = StStop;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StStop: begin
        if (cnt_q == CntBitEnd) begin
          cnt_d   = '0;
          data_d  = shreg_q;
          // A store always sets rdrf, even when rdrf_clr arrives on the same edge.
          rdrf_d  = 1'b1;
          fe_d    = ~rxs;
          oe_d    = rdrf_q & ~rdrf_clr;
          state_d = rxs ? StIdle : StBreak;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StBreak: begin
        if (rxs) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bitn_q  <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      rdrf_q  <= 1'b0;
      fe_q    <= 1'b0;
      oe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bitn_q  <= bitn_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      rdrf_q  <= rdrf_d;
      fe_q    <= fe_d;
      oe_q    <= oe_d;
    end
  end

  assign rx_data = data_q;
  assign rdrf    = rdrf_q;
  assign fe      = fe_q;
  assign oe      = oe_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frame table, hand-written corner cases and
// random frames checked against a frame-level reference model.
module tb_uart_rx;

  localparam int BitTime = 16;
  localparam int HalfBit = 8;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       rxd = 1'b1;
  logic       rdrf_clr = 1'b0;
  logic [7:0] rx_data;
  logic       rdrf, fe, oe;

  uart_rx #(.BIT_TIME(BitTime), .HALF_BIT(HalfBit)) dut (
    .clk     (clk),
    .clr     (clr),
    .RxD     (rxd),
    .rdrf_clr(rdrf_clr),
    .rx_data (rx_data),
    .rdrf    (rdrf),
    .fe      (fe),
    .oe      (oe)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int lat   = 2 + HalfBit + 9 * BitTime;

  // Frame-level reference state
  logic [7:0] m_data = 8'h00;
  logic       m_rdrf = 1'b0, m_fe = 1'b0, m_oe = 1'b0;

  typedef struct {
    logic [7:0] data;
    logic       stopb;
    int         hold;
    int         mode;
    logic       pre_clr;
    int         gap;
    logic [7:0] e_data;
    logic       e_rdrf;
    logic       e_fe;
    logic       e_oe;
  } vec_t;

  vec_t vecs[7];

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] e_data, input logic e_rdrf,
                           input logic e_fe, input logic e_oe);
    check8($sformatf("%s.rx_data", tag), rx_data, e_data);
    check1($sformatf("%s.rdrf", tag), rdrf, e_rdrf);
    check1($sformatf("%s.fe", tag), fe, e_fe);
    check1($sformatf("%s.oe", tag), oe, e_oe);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) tick();
  endtask

  task automatic m_store(input logic [7:0] data, input logic stopb, input logic clr_same);
    m_oe   = m_rdrf & ~clr_same;
    m_rdrf = 1'b1;
    m_data = data;
    m_fe   = ~stopb;
  endtask

  task automatic pulse_rdrf_clr();
    rdrf_clr = 1'b1;
    tick();
    rdrf_clr = 1'b0;
    m_rdrf   = 1'b0;
    check1("pre_clr.rdrf", rdrf, 1'b0);
  endtask

  // mode 0: plain; 1: rdrf_clr 3 cycles after rdrf rises; 2: rdrf_clr on the store edge;
  // 3: clr during data bit 4 (aborts the frame). rise = edge index where rdrf rose, or -1.
  task automatic send_frame(input logic [7:0] data, input logic stopb, input int hold,
                            input int mode, output int rise);
    logic prev;
    int   total;
    rise  = -1;
    prev  = rdrf;
    total = 10 * BitTime + hold;
    for (int c = 0; c < total; c++) begin
      int b;
      b = c / BitTime;
      if (b == 0) rxd = 1'b0;
      else if (b <= 8) rxd = data[b-1];
      else rxd = stopb;
      rdrf_clr = (mode == 1 && rise >= 0 && c == rise + 2) || (mode == 2 && c == lat - 1);
      clr      = (mode == 3 && c == 5 * BitTime + HalfBit);
      tick();
      if (mode == 3 && clr) begin
        clr = 1'b0;
        rxd = 1'b1;
        check_all("clr_mid_frame", 8'h00, 1'b0, 1'b0, 1'b0);
        return;
      end
      if (mode == 1 && rise >= 0 && c == rise + 2) begin
        check1("rdrf_clr.rdrf", rdrf, 1'b0);
        check8("rdrf_clr.rx_data", rx_data, data);
      end
      if (rise < 0 && !prev && rdrf) rise = c + 1;
      prev = rdrf;
    end
    rdrf_clr = 1'b0;
    rxd      = 1'b1;
  endtask

  initial begin
    int rise;
    vecs[0] = '{8'h55, 1'b1, 0,  0, 1'b0, 20,  8'h55, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8'hA3, 1'b1, 0,  1, 1'b1, 20,  8'hA3, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{8'h3C, 1'b0, 40, 0, 1'b0, 200, 8'h3C, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{8'h01, 1'b1, 0,  0, 1'b0, 20,  8'h01, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{8'h11, 1'b1, 0,  0, 1'b1, 20,  8'h11, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{8'h22, 1'b1, 0,  0, 1'b0, 20,  8'h22, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{8'h33, 1'b1, 0,  2, 1'b0, 20,  8'h33, 1'b1, 1'b0, 1'b0};

    clr = 1'b1;
    repeat (3) tick();
    clr = 1'b0;
    tick();
    check_all("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    idle(10);

    foreach (vecs[i]) begin
      if (vecs[i].pre_clr) pulse_rdrf_clr();
      send_frame(vecs[i].data, vecs[i].stopb, vecs[i].hold, vecs[i].mode, rise);
      idle(vecs[i].gap);
      if (i == 0) begin
        tests++;
        if (rise < 2 + HalfBit + 9 * BitTime - 2 || rise > 2 + HalfBit + 9 * BitTime + 2) begin
          fails++;
          $display("FAIL latency: got %0d cycles, expected %0d +/- 2", rise,
                   2 + HalfBit + 9 * BitTime);
        end else begin
          lat = rise;
        end
      end
      m_store(vecs[i].data, vecs[i].stopb, vecs[i].mode == 2);
      if (vecs[i].mode == 1) m_rdrf = 1'b0;
      check_all($sformatf("vec%0d", i), vecs[i].e_data, vecs[i].e_rdrf, vecs[i].e_fe,
                vecs[i].e_oe);
    end

    // Start-bit glitch shorter than half a bit: nothing stored
    rxd = 1'b0;
    repeat (4) tick();
    idle(40);
    check_all("glitch", m_data, m_rdrf, m_fe, m_oe);
    send_frame(8'h7E, 1'b1, 0, 0, rise);
    idle(20);
    m_store(8'h7E, 1'b1, 1'b0);
    check_all("after_glitch", 8'h7E, 1'b1, 1'b0, 1'b1);

    // Reset in the middle of a frame, then a clean frame
    send_frame(8'hFF, 1'b1, 0, 3, rise);
    m_data = 8'h00; m_rdrf = 1'b0; m_fe = 1'b0; m_oe = 1'b0;
    idle(40);
    check_all("clr_idle", 8'h00, 1'b0, 1'b0, 1'b0);
    send_frame(8'h81, 1'b1, 0, 0, rise);
    idle(20);
    m_store(8'h81, 1'b1, 1'b0);
    check_all("after_clr", 8'h81, 1'b1, 1'b0, 1'b0);

    for (int n = 0; n < 24; n++) begin
      logic [7:0] d;
      logic       sb;
      int         hold;
      d    = 8'($urandom);
      sb   = ($urandom_range(0, 3) != 0);
      hold = sb ? 0 : int'($urandom_range(0, 30));
      if ($urandom_range(0, 1) == 1) pulse_rdrf_clr();
      send_frame(d, sb, hold, 0, rise);
      idle(20 + int'($urandom_range(0, 10)));
      m_store(d, sb, 1'b0);
      check_all($sformatf("rand%0d", n), m_data, m_rdrf, m_fe, m_oe);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
